// File: rtl/serial_sched_pkg.sv
// rtl/serial_sched_pkg.sv - shared states, limits and width helpers for the serial load scheduler
package serial_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int N_REQ_MIN  = 1;
    localparam int N_REQ_MAX  = 8;
    localparam int WORD_W_MIN = 2;
    localparam int WORD_W_MAX = 32;

    // Width of a requester index; a single requester still gets one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that runs 0..n-1.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/serial_sched_arb.sv
// rtl/serial_sched_arb.sv - combinational winner select; SERIAL_SCHED_RR_EN selects round-robin, else fixed priority
module serial_sched_arb
    import serial_sched_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] req,
`ifdef SERIAL_SCHED_RR_EN
    input  logic [IDX_W-1:0] ptr,
`endif
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Pick the first requester in search order and report it one-hot and as an index.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
`ifdef SERIAL_SCHED_RR_EN
        for (int i = 0; i < N_REQ; i++) begin
            cand = IDX_W'((int'(ptr) + i) % N_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
`else
        for (int i = 0; i < N_REQ; i++) begin
            cand = IDX_W'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
`endif
        gnt = found ? (N_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/serial_load_sched.sv
// rtl/serial_load_sched.sv - shares one LAT/DCK/SDO load port between requesters; SERIAL_SCHED_RR_EN enables round-robin
module serial_load_sched
    import serial_sched_pkg::*;
#(
    parameter int N_REQ     = 2,
    parameter int WORD_W    = 16,
    parameter int DCK_HALF  = 2,
    parameter int LAT_SETUP = 1,
    parameter int LAT_HOLD  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*WORD_W-1:0] data,
    output logic [N_REQ-1:0]        grant,
    output logic [N_REQ-1:0]        done,
    output logic                    busy,
    output logic                    lat,
    output logic                    dck,
    output logic                    sdo
);

    localparam int IDX_W = idx_w(N_REQ);
    localparam int BIT_W = $clog2(WORD_W + 1);
    localparam int PH_W  = cnt_w(max3(DCK_HALF, LAT_SETUP, LAT_HOLD));

    localparam logic [PH_W-1:0]  DCK_LAST   = PH_W'(DCK_HALF - 1);
    localparam logic [PH_W-1:0]  SETUP_LAST = PH_W'(LAT_SETUP - 1);
    localparam logic [PH_W-1:0]  HOLD_LAST  = PH_W'(LAT_HOLD - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(WORD_W - 1);

    state_t              state_q, state_d;
    logic [PH_W-1:0]     ph_q, ph_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [WORD_W-1:0]   sh_q, sh_d;
    logic [IDX_W-1:0]    win_q, win_d;
    logic [N_REQ-1:0]    grant_d, done_d;
    logic                busy_d, lat_d, dck_d;
    logic [N_REQ-1:0]    arb_gnt;
    logic [IDX_W-1:0]    arb_idx;
`ifdef SERIAL_SCHED_RR_EN
    logic [IDX_W-1:0]    ptr_q, ptr_d;
`endif

    serial_sched_arb #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req (req),
`ifdef SERIAL_SCHED_RR_EN
        .ptr (ptr_q),
`endif
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    // The word's current bit always sits in the MSB, so sdo is a plain register bit.
    assign sdo = sh_q[WORD_W-1];

    // Next-state, counter, shift and output decode for the frame sequence.
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        win_d   = win_q;
        grant_d = '0;
        done_d  = '0;
        lat_d   = lat;
        dck_d   = dck;
`ifdef SERIAL_SCHED_RR_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                lat_d = 1'b0;
                dck_d = 1'b0;
                if (|req) begin
                    state_d = ST_SETUP;
                    ph_d    = '0;
                    bit_d   = '0;
                    sh_d    = data[arb_idx*WORD_W +: WORD_W];
                    win_d   = arb_idx;
                    grant_d = arb_gnt;
                    lat_d   = 1'b1;
`ifdef SERIAL_SCHED_RR_EN
                    ptr_d   = IDX_W'((int'(arb_idx) + 1) % N_REQ);
`endif
                end
            end
            ST_SETUP: begin
                if (ph_q == SETUP_LAST) begin
                    state_d = ST_SHIFT;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (ph_q == DCK_LAST) begin
                    ph_d = '0;
                    if (!dck) begin
                        dck_d = 1'b1;
                    end else if (bit_q == BIT_LAST) begin
                        state_d = ST_HOLD;
                        dck_d   = 1'b0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        sh_d  = {sh_q[WORD_W-2:0], 1'b0};
                        dck_d = 1'b0;
                    end
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (ph_q == HOLD_LAST) begin
                    state_d = ST_DONE;
                    ph_d    = '0;
                    lat_d   = 1'b0;
                    sh_d    = '0;
                    done_d  = N_REQ'(1) << win_q;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                lat_d   = 1'b0;
                dck_d   = 1'b0;
                sh_d    = '0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, counters, shift register and registered outputs; reset abandons any frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ph_q    <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            win_q   <= '0;
            grant   <= '0;
            done    <= '0;
            busy    <= 1'b0;
            lat     <= 1'b0;
            dck     <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            win_q   <= win_d;
            grant   <= grant_d;
            done    <= done_d;
            busy    <= busy_d;
            lat     <= lat_d;
            dck     <= dck_d;
        end
    end

`ifdef SERIAL_SCHED_RR_EN
    // Round-robin pointer, advanced past each winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

endmodule

// File: tb/tb_serial_load_sched.sv
// tb/tb_serial_load_sched.sv - directed self-checking bench for serial_load_sched (default, sweep and 32-bit builds)
module tb_serial_load_sched;

`ifdef SERIAL_SCHED_RR_EN
    localparam logic [1:0]  EXP2_GNT  = 2'b10;
    localparam logic [15:0] EXP2_WORD = 16'h8000;
`else
    localparam logic [1:0]  EXP2_GNT  = 2'b01;
    localparam logic [15:0] EXP2_WORD = 16'h0001;
`endif

    logic clk = 1'b0;
    logic rst;

    logic [1:0]  req_m, grant_m, done_m;
    logic [31:0] data_m;
    logic        busy_m, lat_m, dck_m, sdo_m;

    logic [0:0]  req_s, grant_s, done_s;
    logic [7:0]  data_s;
    logic        busy_s, lat_s, dck_s, sdo_s;

    logic [0:0]  req_w, grant_w, done_w;
    logic [31:0] data_w;
    logic        busy_w, lat_w, dck_w, sdo_w;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_load_sched #(.N_REQ(2), .WORD_W(16), .DCK_HALF(2), .LAT_SETUP(1), .LAT_HOLD(1)) u_m (
        .clk(clk), .rst(rst), .req(req_m), .data(data_m), .grant(grant_m), .done(done_m),
        .busy(busy_m), .lat(lat_m), .dck(dck_m), .sdo(sdo_m));

    serial_load_sched #(.N_REQ(1), .WORD_W(8), .DCK_HALF(1), .LAT_SETUP(3), .LAT_HOLD(2)) u_s (
        .clk(clk), .rst(rst), .req(req_s), .data(data_s), .grant(grant_s), .done(done_s),
        .busy(busy_s), .lat(lat_s), .dck(dck_s), .sdo(sdo_s));

    serial_load_sched #(.N_REQ(1), .WORD_W(32), .DCK_HALF(2), .LAT_SETUP(1), .LAT_HOLD(1)) u_w (
        .clk(clk), .rst(rst), .req(req_w), .data(data_w), .grant(grant_w), .done(done_w),
        .busy(busy_w), .lat(lat_w), .dck(dck_w), .sdo(sdo_w));

    logic [2:0] mon_lat, mon_dck, mon_sdo, mon_done;
    assign mon_lat  = {lat_w, lat_s, lat_m};
    assign mon_dck  = {dck_w, dck_s, dck_m};
    assign mon_sdo  = {sdo_w, sdo_s, sdo_m};
    assign mon_done = {|done_w, |done_s, |done_m};

    int          lat_cnt [3] = '{0, 0, 0};
    int          bit_cnt [3] = '{0, 0, 0};
    int          hi_cnt  [3] = '{0, 0, 0};
    int          viol    [3] = '{0, 0, 0};
    logic [63:0] cap     [3] = '{64'd0, 64'd0, 64'd0};
    logic [2:0]  pd = '0, ps = '0;
    int          g1_cnt = 0, d_cnt = 0;

    // Pin monitor sampled mid-cycle: LAT-high cycles, DCK rising-edge bits, SDO stability while DCK high.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (mon_lat[k]) lat_cnt[k]++;
            if (mon_dck[k]) hi_cnt[k]++;
            if (mon_dck[k] && !pd[k]) begin
                cap[k] = {cap[k][62:0], mon_sdo[k]};
                bit_cnt[k]++;
            end
            if (mon_dck[k] && (mon_sdo[k] !== ps[k])) viol[k]++;
        end
        pd = mon_dck;
        ps = mon_sdo;
        if (grant_m[1]) g1_cnt++;
        if (|done_m) d_cnt++;
    end

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int k, input int lim);
        for (int i = 0; i < lim; i++) begin
            if (mon_done[k]) break;
            tick(1);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b_lat, b_bit, b_hi, b_g1, b_d;
        rst = 1'b1;
        req_m = '0; data_m = '0; req_s = '0; data_s = '0; req_w = '0; data_w = '0;
        #2;
        check_vec("rst_m_outs", {grant_m, done_m, busy_m, lat_m, dck_m, sdo_m}, 64'd0);
        check_vec("rst_s_outs", {grant_s, done_s, busy_s, lat_s, dck_s, sdo_s}, 64'd0);
        tick(2);
        rst = 1'b0;
        tick(1);

        // single request, word A5C3
        b_lat = lat_cnt[0]; b_bit = bit_cnt[0];
        data_m = {16'h0000, 16'hA5C3};
        req_m  = 2'b01;
        tick(1);
        check_vec("t1_grant", grant_m, 2'b01);
        check_vec("t1_busy_lat", {busy_m, lat_m, dck_m, sdo_m}, 4'b1101);
        req_m = 2'b00;
        tick(1);
        check_vec("t1_grant_pulse", grant_m, 2'b00);
        wait_done(0, 200);
        check_vec("t1_done", done_m, 2'b01);
        tick(1);
        check_vec("t1_lat_cycles", lat_cnt[0] - b_lat, 66);
        check_vec("t1_bits", bit_cnt[0] - b_bit, 16);
        check_vec("t1_word", cap[0][15:0], 16'hA5C3);
        check_vec("t1_idle_busy", busy_m, 1'b0);

        // simultaneous requests held high
        pulse_reset();
        data_m = {16'h8000, 16'h0001};
        req_m  = 2'b11;
        tick(1);
        check_vec("t2_first", grant_m, 2'b01);
        tick(67);
        check_vec("t2_gap", grant_m, 2'b00);
        tick(1);
        check_vec("t2_second", grant_m, EXP2_GNT);
        req_m = 2'b00;
        wait_done(0, 200);
        check_vec("t2_done", done_m, EXP2_GNT);
        check_vec("t2_word", cap[0][15:0], EXP2_WORD);
        tick(1);

        // timing sweep: DCK_HALF=1, LAT_SETUP=3, LAT_HOLD=2, WORD_W=8
        b_lat = lat_cnt[1]; b_bit = bit_cnt[1]; b_hi = hi_cnt[1];
        data_s = 8'hB2;
        req_s  = 1'b1;
        tick(1);
        check_vec("t3_grant", grant_s, 1'b1);
        tick(22);
        check_vec("t3_gap", grant_s, 1'b0);
        tick(1);
        check_vec("t3_regrant", grant_s, 1'b1);
        req_s = 1'b0;
        wait_done(1, 100);
        tick(1);
        check_vec("t3_lat_cycles", lat_cnt[1] - b_lat, 42);
        check_vec("t3_bits", bit_cnt[1] - b_bit, 16);
        check_vec("t3_dck_high", hi_cnt[1] - b_hi, 16);
        check_vec("t3_words", cap[1][15:0], 16'hB2B2);

        // reset in the middle of bit 5
        data_m = {16'h0000, 16'hFFFF};
        req_m  = 2'b01;
        tick(1);
        req_m = 2'b00;
        tick(21);
        check_vec("t4_pre", {lat_m, dck_m, sdo_m, busy_m}, 4'b1011);
        #3 rst = 1'b1;
        #1 check_vec("t4_async", {grant_m, done_m, busy_m, lat_m, dck_m, sdo_m}, 64'd0);
        #2 rst = 1'b0;
        b_d = d_cnt;
        tick(80);
        check_vec("t4_no_done", d_cnt - b_d, 0);
        b_bit = bit_cnt[0];
        data_m = {16'h0000, 16'h3C5A};
        req_m  = 2'b01;
        tick(1);
        req_m = 2'b00;
        wait_done(0, 200);
        check_vec("t4_clean_done", done_m, 2'b01);
        check_vec("t4_clean_bits", bit_cnt[0] - b_bit, 16);
        check_vec("t4_clean_word", cap[0][15:0], 16'h3C5A);
        tick(1);

        // data and req changes while shifting
        b_g1 = g1_cnt;
        data_m = {16'h0000, 16'h1234};
        req_m  = 2'b01;
        tick(1);
        check_vec("t5_grant0", grant_m, 2'b01);
        req_m = 2'b00;
        tick(10);
        data_m = {16'h00FF, 16'hFFFF};
        req_m  = 2'b10;
        tick(56);
        check_vec("t5_done0", done_m, 2'b01);
        check_vec("t5_word0", cap[0][15:0], 16'h1234);
        check_vec("t5_no_early_g1", g1_cnt - b_g1, 0);
        tick(2);
        check_vec("t5_grant1", grant_m, 2'b10);
        req_m = 2'b00;
        wait_done(0, 200);
        check_vec("t5_done1", done_m, 2'b10);
        check_vec("t5_word1", cap[0][15:0], 16'h00FF);
        tick(1);

        // 32-bit boundary words
        b_lat = lat_cnt[2]; b_bit = bit_cnt[2];
        data_w = 32'hFFFF_FFFF;
        req_w  = 1'b1;
        tick(1);
        req_w = 1'b0;
        wait_done(2, 300);
        check_vec("t6_done_ones", done_w, 1'b1);
        tick(1);
        check_vec("t6_lat_cycles", lat_cnt[2] - b_lat, 130);
        check_vec("t6_bits_ones", bit_cnt[2] - b_bit, 32);
        check_vec("t6_word_ones", cap[2][31:0], 32'hFFFF_FFFF);
        b_bit = bit_cnt[2];
        data_w = 32'h0;
        req_w  = 1'b1;
        tick(1);
        req_w = 1'b0;
        wait_done(2, 300);
        check_vec("t6_done_zero", done_w, 1'b1);
        tick(1);
        check_vec("t6_bits_zero", bit_cnt[2] - b_bit, 32);
        check_vec("t6_word_zero", cap[2], 64'hFFFF_FFFF_0000_0000);

        check_vec("sdo_stable_m", viol[0], 0);
        check_vec("sdo_stable_s", viol[1], 0);
        check_vec("sdo_stable_w", viol[2], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
